// File: rtl/mb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mb_pkg                                                       |
// | Description : Shared types, constants and helpers for the memory-bus      |
// |               width bridge (byte-lane steering, access-size clamping).     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mb_pkg;

    // Memory-side data width (byte port) and default byte-address width
    localparam int MSZ         = 8;
    localparam int ASZ_DEFAULT = 17;

    typedef enum logic [1:0] {
        BSZ_BYTE = 2'd0,
        BSZ_HALF = 2'd1,
        BSZ_WORD = 2'd2
    } bsz_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Oversized requests silently shrink to the widest access the master supports
    function automatic logic [1:0] bsz_clamp(input logic [1:0] bsz, input logic [1:0] max_bsz);
        return (bsz > max_bsz) ? max_bsz : bsz;
    endfunction

    // Data lane that byte 'idx' of an 'n'-byte access travels on
    function automatic logic [1:0] lane_of(input logic [1:0] idx, input logic [2:0] n,
                                           input logic bigend);
        return bigend ? 2'(n - 3'd1 - {1'b0, idx}) : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mb_width_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mb_width_bridge_if                                           |
// | Description : Master-side access bus of the width bridge: request,        |
// |               size, address, write data, read data and completion.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface mb_width_bridge_if
    import mb_pkg::*;
#(
    parameter int DSZ = 32,
    parameter int ASZ = ASZ_DEFAULT
) ();

    logic           req;
    logic           we;
    logic [1:0]     bsz;
    logic [ASZ-1:0] ai;
    logic [DSZ-1:0] vi;
    logic [DSZ-1:0] vo;
    logic           rdy;
    logic           busy;

    modport master (output req, we, bsz, ai, vi, input  vo, rdy, busy);
    modport slave  (input  req, we, bsz, ai, vi, output vo, rdy, busy);

endinterface
`default_nettype wire

// File: rtl/mb_lane_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mb_lane_mux                                                  |
// | Description : Combinational byte-lane steering. Picks the write byte for  |
// |               the current issue index and decodes the read lane for the   |
// |               current capture index. MB_BIGEND_EN selects big-endian      |
// |               ordering within the access size (default little-endian).    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mb_lane_mux
    import mb_pkg::*;
#(
    parameter int DSZ = 32
) (
    input  logic [DSZ-1:0] i_vi,
    input  logic [1:0]     i_widx,
    input  logic [2:0]     i_n,
    input  logic [1:0]     i_ridx,
    output logic [MSZ-1:0] o_wbyte,
    output logic [1:0]     o_rlane
);

    localparam int c_LANES = DSZ / MSZ;
`ifdef MB_BIGEND_EN
    localparam logic c_BIGEND = 1'b1;
`else
    localparam logic c_BIGEND = 1'b0;
`endif

    logic [1:0] w_wlane;

    // Map issue/capture indices to lanes and select the outgoing write byte
    always_comb begin
        w_wlane = lane_of(i_widx, i_n, c_BIGEND);
        o_rlane = lane_of(i_ridx, i_n, c_BIGEND);
        o_wbyte = '0;
        for (int k = 0; k < c_LANES; k++) begin
            if (w_wlane == 2'(k)) begin
                o_wbyte = i_vi[k*MSZ +: MSZ];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mb_width_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mb_width_bridge                                              |
// | Description : Bridges a DSZ-bit master onto an 8-bit single-port memory. |
// |               Each access is split into 1/2/4 consecutive byte cycles;    |
// |               read bytes are assembled and returned with a rdy pulse.     |
// |               Define MB_BIGEND_EN for big-endian lane ordering.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mb_width_bridge
    import mb_pkg::*;
#(
    parameter int DSZ    = 32,
    parameter int ASZ    = ASZ_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    mb_width_bridge_if.slave bus,
    output logic             m_we,
    output logic [ASZ-1:0]   m_ai,
    output logic [MSZ-1:0]   m_vi,
    input  logic [MSZ-1:0]   m_vo
);

    localparam int         c_LANES   = DSZ / MSZ;
    localparam logic [1:0] c_BSZ_MAX = 2'($clog2(c_LANES));
    localparam logic [1:0] c_S_IDLE  = IDLE;
    localparam logic [1:0] c_S_XFER  = XFER;
    localparam logic [1:0] c_S_DRAIN = DRAIN;
    localparam logic [1:0] c_S_DONE  = DONE;

    logic [1:0]     r_state;
    logic [ASZ-1:0] r_addr;
    logic           r_we;
    logic [2:0]     r_n;
    logic [2:0]     r_idx;
    logic [2:0]     r_ccnt;
    logic [DSZ-1:0] r_vi;
    logic [RD_LAT:0] r_rv;      // bit k: a read byte was issued k cycles ago
    logic [DSZ-1:0] r_vo;
    logic           r_rdy;
    logic           r_busy;

    logic           w_accept;
    logic [2:0]     w_n_in;
    logic           w_issue;
    logic           w_issue_rd;
    logic           w_cap;
    logic           w_cap_last;
    logic [DSZ-1:0] w_src_vi;
    logic [2:0]     w_src_n;
    logic [1:0]     w_src_idx;
    logic [MSZ-1:0] w_wbyte;
    logic [1:0]     w_rlane;

    assign bus.vo   = r_vo;
    assign bus.rdy  = r_rdy;
    assign bus.busy = r_busy;

    // Decode this cycle's accept, issue and capture events; DONE accepts like IDLE
    always_comb begin
        w_accept   = bus.req && (r_state == c_S_IDLE || r_state == c_S_DONE);
        w_n_in     = 3'd1 << bsz_clamp(bus.bsz, c_BSZ_MAX);
        w_issue    = (r_state == c_S_XFER) && (r_idx != r_n);
        w_issue_rd = w_accept ? !bus.we : (w_issue && !r_we);
        w_cap      = r_rv[RD_LAT];
        w_cap_last = w_cap && (r_ccnt == r_n - 3'd1);
        // On the accept edge byte 0 comes straight from the request inputs
        w_src_vi   = w_accept ? bus.vi : r_vi;
        w_src_n    = w_accept ? w_n_in : r_n;
        w_src_idx  = w_accept ? 2'd0 : r_idx[1:0];
    end

    mb_lane_mux #(
        .DSZ (DSZ)
    ) u_lane_mux (
        .i_vi    (w_src_vi),
        .i_widx  (w_src_idx),
        .i_n     (w_src_n),
        .i_ridx  (r_ccnt[1:0]),
        .o_wbyte (w_wbyte),
        .o_rlane (w_rlane)
    );

    // Main FSM: accept a request, issue byte cycles, collect read bytes, pulse rdy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_n     <= 3'd0;
            r_idx   <= 3'd0;
            r_ccnt  <= 3'd0;
            r_vi    <= '0;
            r_rv    <= '0;
            r_vo    <= '0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            m_we    <= 1'b0;
            m_ai    <= '0;
            m_vi    <= '0;
        end else begin
            r_rv <= {r_rv[RD_LAT-1:0], w_issue_rd};

            // Read data arrives in issue order, so a running count names the lane
            if (w_cap) begin
                for (int k = 0; k < c_LANES; k++) begin
                    if (w_rlane == 2'(k)) begin
                        r_vo[k*MSZ +: MSZ] <= m_vo;
                    end
                end
                r_ccnt <= r_ccnt + 3'd1;
            end

            if (w_accept) begin
                r_state <= c_S_XFER;
                r_addr  <= bus.ai;
                r_we    <= bus.we;
                r_n     <= w_n_in;
                r_vi    <= bus.vi;
                r_idx   <= 3'd1;
                r_ccnt  <= 3'd0;
                r_busy  <= 1'b1;
                r_rdy   <= 1'b0;
                m_we    <= bus.we;
                m_ai    <= bus.ai;
                m_vi    <= w_wbyte;
                // Reads zero-extend, so clear upper lanes up front; writes leave vo alone
                if (!bus.we) begin
                    r_vo <= '0;
                end
            end else begin
                case (r_state)
                    c_S_XFER: begin
                        if (w_issue) begin
                            m_we  <= r_we;
                            m_ai  <= r_addr + ASZ'(r_idx);
                            m_vi  <= w_wbyte;
                            r_idx <= r_idx + 3'd1;
                        end else begin
                            m_we <= 1'b0;
                            if (r_we) begin
                                r_state <= c_S_DONE;
                                r_rdy   <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= c_S_DRAIN;
                            end
                        end
                    end
                    c_S_DRAIN: begin
                        if (w_cap_last) begin
                            r_state <= c_S_DONE;
                            r_rdy   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    c_S_DONE: begin
                        r_state <= c_S_IDLE;
                        r_rdy   <= 1'b0;
                    end
                    default: begin
                        r_rdy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mb_width_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mb_width_bridge                                           |
// | Description : Self-checking bench for mb_width_bridge: byte-wide memory   |
// |               model, cycle-level reference model, directed and random     |
// |               stimulus. Honours MB_BIGEND_EN like the design.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mb_width_bridge;
    import mb_pkg::*;

    localparam int DSZ    = 32;
    localparam int ASZ    = 17;
    localparam int RD_LAT = 1;
    localparam int MEMSZ  = 1 << ASZ;
    localparam int MAXB   = $clog2(DSZ / 8);
`ifdef MB_BIGEND_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           m_we;
    logic [ASZ-1:0] m_ai;
    logic [7:0]     m_vi;
    logic [7:0]     m_vo;

    mb_width_bridge_if #(.DSZ(DSZ), .ASZ(ASZ)) bus ();

    mb_width_bridge #(
        .DSZ    (DSZ),
        .ASZ    (ASZ),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .m_we (m_we),
        .m_ai (m_ai),
        .m_vi (m_vi),
        .m_vo (m_vo)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int we_cycles = 0;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 5);
    endfunction

    function automatic int lane(input int i, input int n);
        return BE ? (n - 1 - i) : i;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (time %0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- byte memory with RD_LAT read latency ----------------
    logic [7:0] ram [MEMSZ];
    initial begin
        logic [7:0] rdat;
        logic [7:0] rd_hold;
        rd_hold = '0;
        for (int i = 0; i < MEMSZ; i++) ram[i] = init_byte(i);
        m_vo <= '0;
        forever begin
            @(posedge clk);
            rdat = ram[m_ai];
            if (m_we === 1'b1) ram[m_ai] = m_vi;
            if (RD_LAT >= 2) begin
                m_vo <= rd_hold;
                rd_hold = rdat;
            end else begin
                m_vo <= rdat;
            end
        end
    end

    // ---------------- reference model (timeline per accepted op) ----------------
    logic [7:0]     ref_mem [MEMSZ];
    int             en = 0;        // posedges seen
    int             n_acc = 0;     // accepted ops
    bit             op_act = 0;
    int             e0, op_n, op_len;
    bit             op_we;
    logic [ASZ-1:0] op_a;
    logic [DSZ-1:0] op_vi;
    bit             x_we, x_rdy, x_busy, x_iss, x_rst;
    logic [ASZ-1:0] x_ai;
    logic [7:0]     x_vi;
    logic [DSZ-1:0] vo_exp = '0;
    bit             vo_chk = 1'b0;

    initial begin
        int d;
        for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            en++;
            // byte i of a write lands in memory at the edge ending its issue cycle
            if (op_act && op_we) begin
                d = en - e0;
                if (d >= 1 && d <= op_n)
                    ref_mem[op_a + ASZ'(d - 1)] = op_vi[lane(d - 1, op_n)*8 +: 8];
            end
            if (rst) begin
                op_act = 0; vo_exp = '0; vo_chk = 1;
                x_we = 0; x_rdy = 0; x_busy = 0; x_iss = 0; x_rst = 1;
            end else begin
                x_rst = 0;
                if (op_act && (en - e0) > op_len) op_act = 0;
                if (!op_act && bus.req) begin
                    op_act = 1; e0 = en; n_acc++;
                    op_we = bus.we; op_a = bus.ai; op_vi = bus.vi;
                    op_n = 1 << ((int'(bus.bsz) > MAXB) ? MAXB : int'(bus.bsz));
                    op_len = op_we ? op_n : op_n + RD_LAT;
                    if (!op_we) begin
                        vo_chk = 0;
                        vo_exp = '0;
                        for (int i = 0; i < op_n; i++)
                            vo_exp[lane(i, op_n)*8 +: 8] = ref_mem[op_a + ASZ'(i)];
                    end
                end
                if (op_act) begin
                    d = en - e0;
                    x_busy = d < op_len;
                    x_rdy  = d == op_len;
                    x_iss  = d < op_n;
                    x_we   = op_we && x_iss;
                    x_ai   = op_a + ASZ'(d);
                    if (x_iss) x_vi = op_vi[lane(d, op_n)*8 +: 8];
                    if (x_rdy && !op_we) vo_chk = 1;
                end else begin
                    x_we = 0; x_rdy = 0; x_busy = 0; x_iss = 0;
                end
            end
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (m_we === 1'b1) we_cycles++;
            if (en >= 1) begin
                chk("m_we", 64'(m_we), 64'(x_we));
                chk("rdy",  64'(bus.rdy), 64'(x_rdy));
                chk("busy", 64'(bus.busy), 64'(x_busy));
                if (x_iss)  chk("m_ai", 64'(m_ai), 64'(x_ai));
                if (x_we)   chk("m_vi", 64'(m_vi), 64'(x_vi));
                if (vo_chk) chk("vo", 64'(bus.vo), 64'(vo_exp));
                if (x_rst) begin
                    chk("m_ai_rst", 64'(m_ai), 64'd0);
                    chk("m_vi_rst", 64'(m_vi), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_op(input bit we, input logic [1:0] bsz, input logic [ASZ-1:0] ai,
                         input logic [DSZ-1:0] vi);
        int acc0;
        acc0 = n_acc;
        bus.req = 1'b1; bus.we = we; bus.bsz = bsz; bus.ai = ai; bus.vi = vi;
        for (int k = 0; k < 20 && n_acc == acc0; k++) @(negedge clk);
        bus.req = 1'b0;
        if (n_acc == acc0) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rdy(input string nm);
        int k;
        k = 0;
        while (!x_rdy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 64'(bus.rdy), 64'd1);
    endtask

    task automatic rand_inputs(input bit req_v);
        bus.req = req_v;
        bus.we  = 1'($urandom_range(0, 1));
        bus.bsz = 2'($urandom_range(0, 3));
        bus.ai  = ($urandom_range(0, 3) == 0) ? ASZ'(MEMSZ - 1 - int'($urandom_range(0, 3)))
                                              : ASZ'($urandom);
        bus.vi  = DSZ'($urandom);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] w;
        rst = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.bsz = 2'd0; bus.ai = '0; bus.vi = '0;
        repeat (2) @(negedge clk);
        chk("reset_vo",   64'(bus.vo), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // word write at 0x100
        we_cycles = 0;
        do_op(1'b1, 2'd2, 17'h00100, 32'h44332211);
        wait_rdy("wr_word_rdy");
        chk("wr_word_we_cycles", 64'(we_cycles), 64'd4);
        w = {ram[17'h00103], ram[17'h00102], ram[17'h00101], ram[17'h00100]};
        chk("wr_word_mem", 64'(w), BE ? 64'h11223344 : 64'h44332211);
        chk("model_mem_pin", 64'(ref_mem[17'h00100]), BE ? 64'h44 : 64'h11);

        // word read back
        do_op(1'b0, 2'd2, 17'h00100, '0);
        wait_rdy("rd_word_rdy");
        chk("rd_word_vo", 64'(bus.vo), 64'h44332211);

        // half across the address wrap, then read back as half and as clamped bsz=3
        do_op(1'b1, 2'd1, 17'h1FFFF, 32'h0000BBAA);
        wait_rdy("wr_half_rdy");
        chk("wr_half_wrap_mem", 64'({ram[17'h00000], ram[17'h1FFFF]}), BE ? 64'hAABB : 64'hBBAA);
        do_op(1'b0, 2'd1, 17'h1FFFF, '0);
        wait_rdy("rd_half_rdy");
        chk("rd_half_vo", 64'(bus.vo), 64'h0000BBAA);
        do_op(1'b0, 2'd3, 17'h1FFFF, '0);
        wait_rdy("rd_bsz3_rdy");
        w = bus.vo;
        chk("rd_bsz3_lanes", BE ? 64'(w[31:16]) : 64'(w[15:0]), 64'hBBAA);

        // abort in the second byte cycle of a word write
        do_op(1'b1, 2'd2, 17'h00200, 32'hDDCCBBAA);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_m_we", 64'(m_we), 64'd0);
        chk("abort_rdy",  64'(bus.rdy), 64'd0);
        chk("abort_vo",   64'(bus.vo), 64'd0);
        repeat (4) @(negedge clk);
        do_op(1'b0, 2'd0, 17'h00200, '0);
        wait_rdy("abort_rd_rdy");
        chk("abort_rd_vo", 64'(bus.vo), BE ? 64'h000000DD : 64'h000000AA);

        // req held high: back-to-back acceptance
        repeat (60) begin
            rand_inputs(1'b1);
            @(negedge clk);
        end

        // random requests overlapping busy periods, occasional reset
        repeat (1500) begin
            rand_inputs($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.req = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
